dcache_direct: RTL and testbench
================================

# dcache_direct

Direct-mapped, write-through, read-allocate data cache sitting directly upstream of the word-addressed main memory stage. The CPU load/store path drives it, and it drives the memory's `start`/`rwn`/`address`/`data_in` pins. Read hits return in one cycle. Misses and all writes are forwarded to memory, and the block accounts for the memory's one-cycle registered read latency.

## Interface
Parameters:
- `ADDR_WIDTH`, 16, byte-free word address width (matches memory `memory_size`).
- `WORD_SIZE`, 32, data word width.
- `INDEX_BITS`, 6, line index width (64 lines, one word per line). Tag width = `ADDR_WIDTH - INDEX_BITS` (10).

Ports:
- `clk`  in  1  single clock, all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `cpu_req`  in  1  request strobe, sampled only in IDLE.
- `cpu_rwn`  in  1  1 = read, 0 = write.
- `cpu_address`  in  ADDR_WIDTH  word address.
- `cpu_data_in`  in  WORD_SIZE  write data.
- `cpu_data_out`  out  WORD_SIZE  read data, valid when `cpu_ready`=1.
- `cpu_ready`  out  1  one-cycle completion pulse.
- `cpu_busy`  out  1  high whenever state ≠ IDLE.
- `mem_start`  out  1  memory access strobe.
- `mem_rwn`  out  1  memory direction.
- `mem_address`  out  ADDR_WIDTH  memory address.
- `mem_data_in`  out  WORD_SIZE  memory write data.
- `mem_data_out`  in  WORD_SIZE  memory read data, valid the cycle after a read strobe.
- `hit_count`, `miss_count`  out  16 each  saturating statistics counters.

## Operation
- Address split: index = `cpu_address[INDEX_BITS-1:0]`, tag = upper bits. Hit = `valid[index] && tag_array[index]==tag`.
- States:
  - **IDLE** (default).
  - **RD_MEM**: `mem_start`=1, `mem_rwn`=1.
  - **RD_FILL**: capture `mem_data_out`.
  - **WR_MEM**: `mem_start`=1, `mem_rwn`=0.
- IDLE, `cpu_req`=1:
  - Read hit: register line data into `cpu_data_out`, pulse `cpu_ready`, stay IDLE, `hit_count`++.
  - Read miss: latch address, go to RD_MEM, `miss_count`++.
  - Write: latch address and data, go to WR_MEM.
- RD_MEM → RD_FILL unconditionally.
- RD_FILL: write `mem_data_out` into the data array, write the tag, set the valid bit, drive `cpu_data_out` = `mem_data_out`, pulse `cpu_ready`, go to IDLE.
- WR_MEM: memory writes the latched data. If the latched address hits, update the line data (write-through, update-on-hit). A write miss does not allocate. Pulse `cpu_ready`, go to IDLE. Writes do not touch the counters.
- `mem_*` outputs are decoded from state plus the latched request registers. Outside RD_MEM/WR_MEM, `mem_start`=0.
- `cpu_req` during a non-IDLE state is ignored. The CPU must re-present the request after `cpu_ready`.
- Counters saturate at 16'hFFFF; they never wrap.

## Timing
- Read hit: request in cycle 0, `cpu_ready`+data in cycle 1. A new request can be accepted in cycle 1.
- Read miss:
  - Cycle 0: request.
  - Cycle 1: `mem_start`.
  - Cycle 2: fill.
  - Cycle 3: `cpu_ready`.
- Write:
  - Cycle 0: request.
  - Cycle 1: `mem_start` with `rwn`=0.
  - Cycle 2: `cpu_ready`.
- `cpu_ready` is high for exactly one cycle per accepted request.
- Reset (including mid-transaction) takes effect at the next edge:
  - state = IDLE, all valid bits = 0.
  - `cpu_ready`=0, `cpu_data_out`=0, `mem_start`=0, counters = 0.
  - Any in-flight transaction is dropped with no `cpu_ready`.
  - Tag/data arrays need no reset.
- Read following a write to the same address: it must return the written value. A hit line is updated in WR_MEM; a miss is refetched from memory.

## Structure
- Package `dcache_pkg`:
  - state enum (IDLE, RD_MEM, RD_FILL, WR_MEM).
  - derived `TAG_BITS` and `NUM_LINES` constants.
  - `COUNT_MAX` = 16'hFFFF.
- Sub-module `dcache_line_store`:
  - tag, data and valid arrays.
  - one combinational read port (index → tag, data, valid).
  - one synchronous write port with a separate valid-set/clear-all control.
- The top level holds the FSM, the request latch and the counters.

## Test plan
- **Cold read miss:** reset, memory word 0x0040 = 0xDEADBEEF, read 0x0040.
  - `mem_start`/`rwn`=1 in cycle 1.
  - `cpu_ready` with 0xDEADBEEF in cycle 3.
  - `miss_count`=1.
- **Read hit:** repeat the 0x0040 read.
  - `cpu_ready` in cycle 1 with 0xDEADBEEF.
  - no `mem_start`.
  - `hit_count`=1.
- **Write-through on hit:** write 0x12345678 to 0x0040.
  - `mem_start`, `rwn`=0, `mem_data_in`=0x12345678 in cycle 1; `cpu_ready` in cycle 2.
  - Next read of 0x0040 hits and returns 0x12345678.
- **Conflict eviction:** read 0x0040, then read 0x0080 (same index, different tag).
  - second read misses.
  - re-reading 0x0040 misses again.
- **Reset mid-miss:** assert `reset` in RD_FILL.
  - no `cpu_ready`, state IDLE, counters 0.
  - next read of the same address misses.
- **Ignored request and saturation:** hold `cpu_req` high during the miss states.
  - no extra transaction is accepted.
  - preload `hit_count`=16'hFFFE, issue 3 hits, count reads 16'hFFFF.

Source files
------------

// File: rtl/dcache_pkg.sv
// dcache_pkg: shared states and constants for the direct-mapped write-through data cache
package dcache_pkg;
    localparam int ADDR_BITS = 16;
    localparam int INDEX_W = 6;
    localparam int TAG_BITS = ADDR_BITS - INDEX_W;
    localparam int NUM_LINES = 1 << INDEX_W;
    localparam logic [15:0] COUNT_MAX = 16'hFFFF;
    typedef enum logic [1:0] {IDLE, RD_MEM, RD_FILL, WR_MEM} state_t;
endpackage

// File: rtl/dcache_line_store.sv
// dcache_line_store: tag/data/valid arrays with a combinational read port and a synchronous write port
module dcache_line_store
    import dcache_pkg::*;
#(
    parameter int INDEX_BITS = 6,
    parameter int TAG_W = TAG_BITS,
    parameter int WORD_SIZE = 32
) (
    input  logic                  clk,
    input  logic                  clear_all,
    input  logic [INDEX_BITS-1:0] rd_index,
    output logic [TAG_W-1:0]      rd_tag,
    output logic [WORD_SIZE-1:0]  rd_data,
    output logic                  rd_valid,
    input  logic                  wr_en,
    input  logic                  set_valid,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic [TAG_W-1:0]      wr_tag,
    input  logic [WORD_SIZE-1:0]  wr_data
);
    localparam int LINES = 1 << INDEX_BITS;
    logic [TAG_W-1:0]     tags [LINES];
    logic [WORD_SIZE-1:0] data [LINES];
    logic [LINES-1:0]     valid;
    assign rd_tag   = tags[rd_index];
    assign rd_data  = data[rd_index];
    assign rd_valid = valid[rd_index];
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_index] <= wr_tag;
            data[wr_index] <= wr_data;
        end
    end
    // clear_all wins over a same-cycle fill so a reset always leaves every line invalid
    always_ff @(posedge clk) begin
        if (clear_all)
            valid <= '0;
        else if (wr_en && set_valid)
            valid[wr_index] <= 1'b1;
    end
endmodule

// File: rtl/dcache_direct.sv
// dcache_direct: direct-mapped, write-through, read-allocate cache in front of a one-cycle-latency memory
module dcache_direct
    import dcache_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int WORD_SIZE = 32,
    parameter int INDEX_BITS = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_rwn,
    input  logic [ADDR_WIDTH-1:0] cpu_address,
    input  logic [WORD_SIZE-1:0]  cpu_data_in,
    output logic [WORD_SIZE-1:0]  cpu_data_out,
    output logic                  cpu_ready,
    output logic                  cpu_busy,
    output logic                  mem_start,
    output logic                  mem_rwn,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [WORD_SIZE-1:0]  mem_data_in,
    input  logic [WORD_SIZE-1:0]  mem_data_out,
    output logic [15:0]           hit_count,
    output logic [15:0]           miss_count
);
    localparam int TW = ADDR_WIDTH - INDEX_BITS;
    state_t state, state_n;
    logic [ADDR_WIDTH-1:0] req_addr, look_addr;
    logic [WORD_SIZE-1:0]  req_data, line_data;
    logic [TW-1:0]         line_tag;
    logic line_valid, hit, rd_hit, rd_miss, wr_line;
    // in WR_MEM the lookup uses the latched address to decide update-on-hit
    assign look_addr = (state == IDLE) ? cpu_address : req_addr;
    assign hit       = line_valid && (line_tag == look_addr[ADDR_WIDTH-1:INDEX_BITS]);
    assign rd_hit    = (state == IDLE) && cpu_req && cpu_rwn && hit;
    assign rd_miss   = (state == IDLE) && cpu_req && cpu_rwn && !hit;
    assign wr_line   = (state == RD_FILL) || ((state == WR_MEM) && hit);
    dcache_line_store #(.INDEX_BITS(INDEX_BITS), .TAG_W(TW), .WORD_SIZE(WORD_SIZE)) store (
        .clk(clk),
        .clear_all(reset),
        .rd_index(look_addr[INDEX_BITS-1:0]),
        .rd_tag(line_tag),
        .rd_data(line_data),
        .rd_valid(line_valid),
        .wr_en(wr_line),
        .set_valid(state == RD_FILL),
        .wr_index(req_addr[INDEX_BITS-1:0]),
        .wr_tag(req_addr[ADDR_WIDTH-1:INDEX_BITS]),
        .wr_data((state == RD_FILL) ? mem_data_out : req_data)
    );
    always_comb begin
        state_n = IDLE;
        if (state == IDLE)
            state_n = cpu_req ? (cpu_rwn ? (hit ? IDLE : RD_MEM) : WR_MEM) : IDLE;
        else if (state == RD_MEM)
            state_n = RD_FILL;
    end
    assign cpu_busy    = state != IDLE;
    assign mem_start   = (state == RD_MEM) || (state == WR_MEM);
    assign mem_rwn     = state != WR_MEM;
    assign mem_address = req_addr;
    assign mem_data_in = req_data;
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cpu_ready    <= 1'b0;
            cpu_data_out <= '0;
            hit_count    <= '0;
            miss_count   <= '0;
        end else begin
            state     <= state_n;
            cpu_ready <= rd_hit || (state == RD_FILL) || (state == WR_MEM);
            if (rd_hit)
                cpu_data_out <= line_data;
            else if (state == RD_FILL)
                cpu_data_out <= mem_data_out;
            if (rd_hit && hit_count != COUNT_MAX)
                hit_count <= hit_count + 16'd1;
            if (rd_miss && miss_count != COUNT_MAX)
                miss_count <= miss_count + 16'd1;
        end
    end
    always_ff @(posedge clk) begin
        if (state == IDLE && cpu_req) begin
            req_addr <= cpu_address;
            req_data <= cpu_data_in;
        end
    end
endmodule

// File: tb/tb_dcache_direct.sv
// tb_dcache_direct: table-driven check of the cache against a registered-read memory model
module tb_dcache_direct;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_rwn = 1'b1;
    logic [15:0] cpu_address = '0;
    logic [31:0] cpu_data_in = '0;
    logic [31:0] cpu_data_out;
    logic        cpu_ready, cpu_busy, mem_start, mem_rwn;
    logic [15:0] mem_address;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out = '0;
    logic [15:0] hit_count, miss_count;
    logic [31:0] mem [0:65535];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dcache_direct dut (
        .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_rwn(cpu_rwn),
        .cpu_address(cpu_address), .cpu_data_in(cpu_data_in), .cpu_data_out(cpu_data_out),
        .cpu_ready(cpu_ready), .cpu_busy(cpu_busy), .mem_start(mem_start), .mem_rwn(mem_rwn),
        .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    // memory model: writes land at the strobe edge, reads appear one cycle after the strobe
    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
        mem[16'h0040] = 32'hDEADBEEF;
        mem[16'h0080] = 32'hCAFEF00D;
        mem[16'h00C0] = 32'h0BADF00D;
        mem[16'h0141] = 32'h11111111;
        forever begin
            @(posedge clk);
            if (mem_start && !mem_rwn) mem[mem_address] = mem_data_in;
            if (mem_start && mem_rwn) mem_data_out <= mem[mem_address];
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // issues one request at a negedge and returns ready latency, data and cycle-1 memory pins
    task automatic txn(input logic rwn, input logic [15:0] a, input logic [31:0] d,
                       output int lat, output logic [31:0] q, output logic s1,
                       output logic r1, output logic [15:0] ma1, output logic [31:0] md1);
        cpu_req = 1'b1; cpu_rwn = rwn; cpu_address = a; cpu_data_in = d;
        lat = 0; q = '0; s1 = 1'b0; r1 = 1'b0; ma1 = '0; md1 = '0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) begin
                cpu_req = 1'b0;
                s1 = mem_start; r1 = mem_rwn; ma1 = mem_address; md1 = mem_data_in;
            end
            if (cpu_ready) begin
                lat = k;
                q = cpu_data_out;
                break;
            end
        end
    endtask

    typedef struct {
        logic        rwn;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_q;
        int          exp_lat;
        logic        exp_start;
        logic [15:0] exp_hc;
        logic [15:0] exp_mc;
    } vec_t;

    vec_t vecs [9];
    int lat;
    logic [31:0] q, md1;
    logic s1, r1;
    logic [15:0] ma1;

    initial begin
        vecs[0] = '{1'b1, 16'h0040, 32'h0,        32'hDEADBEEF, 3, 1'b1, 16'd0, 16'd1};
        vecs[1] = '{1'b1, 16'h0040, 32'h0,        32'hDEADBEEF, 1, 1'b0, 16'd1, 16'd1};
        vecs[2] = '{1'b0, 16'h0040, 32'h12345678, 32'h0,        2, 1'b1, 16'd1, 16'd1};
        vecs[3] = '{1'b1, 16'h0040, 32'h0,        32'h12345678, 1, 1'b0, 16'd2, 16'd1};
        vecs[4] = '{1'b1, 16'h0080, 32'h0,        32'hCAFEF00D, 3, 1'b1, 16'd2, 16'd2};
        vecs[5] = '{1'b1, 16'h0040, 32'h0,        32'h12345678, 3, 1'b1, 16'd2, 16'd3};
        vecs[6] = '{1'b0, 16'h0141, 32'hA5A5A5A5, 32'h0,        2, 1'b1, 16'd2, 16'd3};
        vecs[7] = '{1'b1, 16'h0141, 32'h0,        32'hA5A5A5A5, 3, 1'b1, 16'd2, 16'd4};
        vecs[8] = '{1'b1, 16'h0141, 32'h0,        32'hA5A5A5A5, 1, 1'b0, 16'd3, 16'd4};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset ready", {31'b0, cpu_ready}, 32'd0);
        check("reset data", cpu_data_out, 32'd0);
        check("reset start", {31'b0, mem_start}, 32'd0);
        check("reset busy", {31'b0, cpu_busy}, 32'd0);
        check("reset hits", {16'b0, hit_count}, 32'd0);
        check("reset misses", {16'b0, miss_count}, 32'd0);

        for (int i = 0; i < 9; i++) begin
            txn(vecs[i].rwn, vecs[i].addr, vecs[i].wdata, lat, q, s1, r1, ma1, md1);
            check($sformatf("v%0d latency", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d mem_start", i), {31'b0, s1}, {31'b0, vecs[i].exp_start});
            if (vecs[i].exp_start) begin
                check($sformatf("v%0d mem_rwn", i), {31'b0, r1}, {31'b0, vecs[i].rwn});
                check($sformatf("v%0d mem_address", i), {16'b0, ma1}, {16'b0, vecs[i].addr});
            end
            if (vecs[i].rwn)
                check($sformatf("v%0d data", i), q, vecs[i].exp_q);
            else
                check($sformatf("v%0d mem_data_in", i), md1, vecs[i].wdata);
            check($sformatf("v%0d hits", i), {16'b0, hit_count}, {16'b0, vecs[i].exp_hc});
            check($sformatf("v%0d misses", i), {16'b0, miss_count}, {16'b0, vecs[i].exp_mc});
        end

        // reset during RD_FILL drops the miss and invalidates every line
        cpu_req = 1'b1; cpu_rwn = 1'b1; cpu_address = 16'h00C0;
        @(negedge clk);
        cpu_req = 1'b0;
        @(negedge clk);
        check("fill busy", {31'b0, cpu_busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset ready", {31'b0, cpu_ready}, 32'd0);
        check("midreset busy", {31'b0, cpu_busy}, 32'd0);
        check("midreset data", cpu_data_out, 32'd0);
        check("midreset hits", {16'b0, hit_count}, 32'd0);
        check("midreset misses", {16'b0, miss_count}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("dropped ready", {31'b0, cpu_ready}, 32'd0);
        end
        txn(1'b1, 16'h00C0, 32'h0, lat, q, s1, r1, ma1, md1);
        check("refetch latency", lat, 3);
        check("refetch data", q, 32'h0BADF00D);
        txn(1'b1, 16'h0040, 32'h0, lat, q, s1, r1, ma1, md1);
        check("invalidated latency", lat, 3);
        check("invalidated data", q, 32'h12345678);
        check("post reset misses", {16'b0, miss_count}, 32'd2);

        // request held high through the miss states must not start a second access
        cpu_req = 1'b1; cpu_rwn = 1'b1; cpu_address = 16'h0080;
        @(negedge clk);
        check("held start c1", {31'b0, mem_start}, 32'd1);
        cpu_rwn = 1'b0; cpu_address = 16'h0100; cpu_data_in = 32'hFFFFFFFF;
        check("held addr c1", {16'b0, mem_address}, 32'h0080);
        @(negedge clk);
        check("held start c2", {31'b0, mem_start}, 32'd0);
        check("held ready c2", {31'b0, cpu_ready}, 32'd0);
        cpu_rwn = 1'b1; cpu_address = 16'h0080;
        @(negedge clk);
        cpu_req = 1'b0;
        check("held ready c3", {31'b0, cpu_ready}, 32'd1);
        check("held data c3", cpu_data_out, 32'hCAFEF00D);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("held no start", {31'b0, mem_start}, 32'd0);
            check("held no ready", {31'b0, cpu_ready}, 32'd0);
        end
        check("held misses", {16'b0, miss_count}, 32'd3);
        check("ignored write", mem[16'h0100], 32'h0);

        // back-to-back hits drive the hit counter into saturation
        cpu_req = 1'b1; cpu_rwn = 1'b1; cpu_address = 16'h0080;
        repeat (65534) @(negedge clk);
        check("hits preload", {16'b0, hit_count}, 32'h0000FFFE);
        repeat (3) @(negedge clk);
        cpu_req = 1'b0;
        check("hits saturated", {16'b0, hit_count}, 32'h0000FFFF);
        check("sat ready", {31'b0, cpu_ready}, 32'd1);
        check("sat misses", {16'b0, miss_count}, 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
